// File: rtl/data_demux.sv
// 1-to-2 data demultiplexer: steers each accepted word into the A or B FIFO buffer
// and keeps a saturating per-port count of accepted words.

module data_demux_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int AW     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_pop,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_not_full
);
  localparam logic [AW:0]   L_DEPTH   = (AW+1)'(DEPTH);
  localparam logic [AW:0]   L_OCC_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] L_PTR_ONE = AW'(1);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wptr;
  logic [AW-1:0]     r_rptr;
  logic [AW:0]       r_occ;

  // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_occ  <= '0;
    end else begin
      if (i_push) r_wptr <= r_wptr + L_PTR_ONE;
      if (i_pop)  r_rptr <= r_rptr + L_PTR_ONE;
      case ({i_push, i_pop})
        2'b10:   r_occ <= r_occ + L_OCC_ONE;
        2'b01:   r_occ <= r_occ - L_OCC_ONE;
        default: r_occ <= r_occ;
      endcase
    end
  end

  // Storage array; the datapath needs no reset.
  always_ff @(posedge clk) begin
    if (i_push && !rst) r_mem[r_wptr] <= i_data;
  end

  assign o_data     = r_mem[r_rptr];
  assign o_valid    = (r_occ != '0);
  assign o_not_full = (r_occ < L_DEPTH);
endmodule

module data_demux #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sel,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] a_data,
  output logic              a_valid,
  input  logic              a_ready,
  output logic [DATA_W-1:0] b_data,
  output logic              b_valid,
  input  logic              b_ready,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  a_count,
  output logic [CNT_W-1:0]  b_count
);
  localparam int              AW        = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] L_CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] L_CNT_ONE = CNT_W'(1);

  logic w_a_not_full, w_b_not_full;
  logic w_a_valid, w_b_valid;
  logic w_in_ready;
  logic w_push_a, w_push_b, w_pop_a, w_pop_b;
  logic [CNT_W-1:0] r_a_cnt, r_b_cnt;

  // Acceptance depends only on the selected buffer's registered occupancy.
  always_comb begin
    w_in_ready = 1'b0;
    if (rst) begin
      w_in_ready = 1'b0;
    end else if (in_sel) begin
      w_in_ready = w_a_not_full;
    end else begin
      w_in_ready = w_b_not_full;
    end
  end

  assign in_ready = w_in_ready;
  assign a_valid  = w_a_valid && !rst;
  assign b_valid  = w_b_valid && !rst;
  assign w_push_a = in_valid && w_in_ready && in_sel;
  assign w_push_b = in_valid && w_in_ready && !in_sel;
  assign w_pop_a  = a_valid && a_ready;
  assign w_pop_b  = b_valid && b_ready;

  data_demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_fifo_a (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push_a),
    .i_data     (in_data),
    .i_pop      (w_pop_a),
    .o_data     (a_data),
    .o_valid    (w_a_valid),
    .o_not_full (w_a_not_full)
  );

  data_demux_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW)) u_fifo_b (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push_b),
    .i_data     (in_data),
    .i_pop      (w_pop_b),
    .o_data     (b_data),
    .o_valid    (w_b_valid),
    .o_not_full (w_b_not_full)
  );

  // Saturating transfer counters; a clear wins over a same-cycle push.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_a_cnt <= '0;
      r_b_cnt <= '0;
    end else begin
      if (w_push_a && (r_a_cnt != L_CNT_MAX)) r_a_cnt <= r_a_cnt + L_CNT_ONE;
      if (w_push_b && (r_b_cnt != L_CNT_MAX)) r_b_cnt <= r_b_cnt + L_CNT_ONE;
    end
  end

  assign a_count = r_a_cnt;
  assign b_count = r_b_cnt;
endmodule

// File: tb/tb_data_demux.sv
// Directed bench for data_demux: a vector table for steering/backpressure/clear,
// plus hand-written sequences for reset mid-operation, streaming and counter saturation.

module tb_data_demux;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (CNT_W = 16)
  logic        rst, in_sel, in_valid, in_ready, a_valid, a_ready, b_valid, b_ready, cnt_clr;
  logic [31:0] in_data, a_data, b_data;
  logic [15:0] a_count, b_count;

  // narrow-counter DUT (CNT_W = 4)
  logic        c_rst, c_sel, c_valid, c_in_ready, c_a_valid, c_a_ready, c_b_valid, c_b_ready, c_clr;
  logic [31:0] c_data, c_a_data, c_b_data;
  logic [3:0]  c_a_count, c_b_count;

  data_demux #(.DATA_W(32), .DEPTH(2), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel), .in_valid(in_valid),
    .in_ready(in_ready), .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
    .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready), .cnt_clr(cnt_clr),
    .a_count(a_count), .b_count(b_count)
  );

  data_demux #(.DATA_W(32), .DEPTH(2), .CNT_W(4)) dut4 (
    .clk(clk), .rst(c_rst), .in_data(c_data), .in_sel(c_sel), .in_valid(c_valid),
    .in_ready(c_in_ready), .a_data(c_a_data), .a_valid(c_a_valid), .a_ready(c_a_ready),
    .b_data(c_b_data), .b_valid(c_b_valid), .b_ready(c_b_ready), .cnt_clr(c_clr),
    .a_count(c_a_count), .b_count(c_b_count)
  );

  typedef struct packed {
    logic [5:0]  ctl;   // rst, in_valid, in_sel, a_ready, b_ready, cnt_clr
    logic [31:0] d;
    logic [2:0]  ef;    // expected in_ready, a_valid, b_valid
    logic [31:0] ead;
    logic [31:0] ebd;
    logic [15:0] eac;
    logic [15:0] ebc;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic void add(input logic [5:0] ctl, input logic [31:0] d, input logic [2:0] ef,
                              input logic [31:0] ead, input logic [31:0] ebd,
                              input logic [15:0] eac, input logic [15:0] ebc);
    vec_t v;
    v.ctl = ctl; v.d = d; v.ef = ef; v.ead = ead; v.ebd = ebd; v.eac = eac; v.ebc = ebc;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [31:0] qa[$];
  logic [31:0] qb[$];
  int got_a, got_b, stalls;

  task automatic check_pops();
    logic [31:0] e;
    if (a_valid) begin
      e = (qa.size() > 0) ? qa.pop_front() : 32'hDEAD_BEEF;
      chk("stream_a_data", {32'h0, a_data}, {32'h0, e});
      got_a++;
    end
    if (b_valid) begin
      e = (qb.size() > 0) ? qb.pop_front() : 32'hDEAD_BEEF;
      chk("stream_b_data", {32'h0, b_data}, {32'h0, e});
      got_b++;
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = 32'h0;
    a_ready = 1'b0; b_ready = 1'b0; cnt_clr = 1'b0;
    c_rst = 1'b1; c_valid = 1'b0; c_sel = 1'b0; c_data = 32'h0;
    c_a_ready = 1'b1; c_b_ready = 1'b1; c_clr = 1'b0;
    repeat (2) @(posedge clk);

    //   rst iv sel ar br clr     data          ir av bv  a_data        b_data        a_cnt   b_cnt
    add(6'b100110, 32'h0,  3'b000, 32'h0,  32'h0,  16'd0, 16'd0);
    add(6'b011110, 32'h1,  3'b100, 32'h0,  32'h0,  16'd0, 16'd0);
    add(6'b010110, 32'h2,  3'b110, 32'h1,  32'h0,  16'd1, 16'd0);
    add(6'b000110, 32'h0,  3'b101, 32'h0,  32'h2,  16'd1, 16'd1);
    add(6'b011010, 32'h11, 3'b100, 32'h0,  32'h0,  16'd1, 16'd1);
    add(6'b011010, 32'h12, 3'b110, 32'h11, 32'h0,  16'd2, 16'd1);
    add(6'b011010, 32'h13, 3'b010, 32'h11, 32'h0,  16'd3, 16'd1);
    add(6'b000010, 32'h0,  3'b110, 32'h11, 32'h0,  16'd3, 16'd1);
    add(6'b011110, 32'h13, 3'b010, 32'h11, 32'h0,  16'd3, 16'd1);
    add(6'b011010, 32'h13, 3'b110, 32'h12, 32'h0,  16'd3, 16'd1);
    add(6'b001110, 32'h0,  3'b010, 32'h12, 32'h0,  16'd4, 16'd1);
    add(6'b001110, 32'h0,  3'b110, 32'h13, 32'h0,  16'd4, 16'd1);
    add(6'b001110, 32'h0,  3'b100, 32'h0,  32'h0,  16'd4, 16'd1);
    add(6'b011010, 32'h21, 3'b100, 32'h0,  32'h0,  16'd4, 16'd1);
    add(6'b001110, 32'h0,  3'b110, 32'h21, 32'h0,  16'd5, 16'd1);
    add(6'b010101, 32'h31, 3'b100, 32'h0,  32'h0,  16'd5, 16'd1);
    add(6'b000100, 32'h0,  3'b101, 32'h0,  32'h31, 16'd0, 16'd0);

    foreach (vq[i]) begin
      @(negedge clk);
      {rst, in_valid, in_sel, a_ready, b_ready, cnt_clr} = vq[i].ctl;
      in_data = vq[i].d;
      #1;
      chk($sformatf("v%0d_in_ready", i), {63'h0, in_ready}, {63'h0, vq[i].ef[2]});
      chk($sformatf("v%0d_a_valid", i),  {63'h0, a_valid},  {63'h0, vq[i].ef[1]});
      chk($sformatf("v%0d_b_valid", i),  {63'h0, b_valid},  {63'h0, vq[i].ef[0]});
      if (vq[i].ef[1]) chk($sformatf("v%0d_a_data", i), {32'h0, a_data}, {32'h0, vq[i].ead});
      if (vq[i].ef[0]) chk($sformatf("v%0d_b_data", i), {32'h0, b_data}, {32'h0, vq[i].ebd});
      chk($sformatf("v%0d_a_count", i), {48'h0, a_count}, {48'h0, vq[i].eac});
      chk($sformatf("v%0d_b_count", i), {48'h0, b_count}, {48'h0, vq[i].ebc});
    end

    // Reset mid-operation: B already holds 0x31; fill A with two and B with one more.
    @(negedge clk); in_valid = 1'b1; in_sel = 1'b1; in_data = 32'h41; a_ready = 1'b0; b_ready = 1'b0;
    @(negedge clk); in_data = 32'h42;
    @(negedge clk); in_sel = 1'b0; in_data = 32'h43;
    @(negedge clk); in_valid = 1'b0; #1;
    chk("rmid_a_valid_pre", {63'h0, a_valid}, 64'h1);
    chk("rmid_b_valid_pre", {63'h0, b_valid}, 64'h1);
    chk("rmid_b_full", {63'h0, in_ready}, 64'h0);
    chk("rmid_a_count_pre", {48'h0, a_count}, 64'd2);
    rst = 1'b1; #1;
    chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
    chk("rst_a_valid", {63'h0, a_valid}, 64'h0);
    @(negedge clk); rst = 1'b0; #1;
    chk("rmid_a_valid", {63'h0, a_valid}, 64'h0);
    chk("rmid_b_valid", {63'h0, b_valid}, 64'h0);
    chk("rmid_a_count", {48'h0, a_count}, 64'd0);
    chk("rmid_b_count", {48'h0, b_count}, 64'd0);
    chk("rmid_in_ready_b", {63'h0, in_ready}, 64'h1);
    in_sel = 1'b1; #1;
    chk("rmid_in_ready_a", {63'h0, in_ready}, 64'h1);

    // Streaming: 100 words alternating A/B with both consumers always ready.
    got_a = 0; got_b = 0; stalls = 0;
    a_ready = 1'b1; b_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      in_valid = 1'b1; in_sel = (i % 2 == 0); in_data = 32'h1000 + 32'(i);
      #1;
      check_pops();
      if (!in_ready) stalls++;
      else if (in_sel) qa.push_back(in_data);
      else qb.push_back(in_data);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); in_valid = 1'b0; #1;
      check_pops();
    end
    chk("stream_stalls", 64'(stalls), 64'd0);
    chk("stream_got_a", 64'(got_a), 64'd50);
    chk("stream_got_b", 64'(got_b), 64'd50);
    chk("stream_a_count", {48'h0, a_count}, 64'd50);
    chk("stream_b_count", {48'h0, b_count}, 64'd50);

    // Counter saturation on the 4-bit instance, then clear with a concurrent push.
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      c_rst = 1'b0; c_valid = 1'b1; c_sel = 1'b0; c_data = 32'(i);
      #1;
      chk($sformatf("sat_in_ready%0d", i), {63'h0, c_in_ready}, 64'h1);
    end
    @(negedge clk); c_valid = 1'b0; #1;
    chk("sat_b_count", {60'h0, c_b_count}, 64'd15);
    chk("sat_a_count", {60'h0, c_a_count}, 64'd0);
    c_valid = 1'b1; c_clr = 1'b1;
    @(negedge clk); c_valid = 1'b0; c_clr = 1'b0; #1;
    chk("clr_b_count", {60'h0, c_b_count}, 64'd0);
    chk("clr_b_valid", {63'h0, c_b_valid}, 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/data_demux.md
DATA_DEMUX -- requirements
Module: data_demux

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of the data path.
REQ-002 SHALL have parameter DEPTH, default 2, entries per output buffer (power of two, at least 2).
REQ-003 SHALL have parameter CNT_W, default 16, width of the per-port transfer counters.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-005 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-006 SHALL have port in_data  input  DATA_W  word to be steered.
REQ-007 SHALL have port in_sel  input  1  destination: 1 -> port A, 0 -> port B (the inverse of the 2x1 mux select mapping).
REQ-008 SHALL have port in_valid  input  1  in_data/in_sel are valid.
REQ-009 SHALL have port in_ready  output  1  block accepts the offered word this cycle.
REQ-010 SHALL have port a_data  output  DATA_W  head word of the A buffer.
REQ-011 SHALL have port a_valid  output  1  A buffer is non-empty.
REQ-012 SHALL have port a_ready  input  1  A consumer takes the head word.
REQ-013 SHALL have ports b_data, b_valid and b_ready, identical to REQ-010..012 for port B.
REQ-014 SHALL have port cnt_clr  input  1  synchronous clear of both transfer counters.
REQ-015 SHALL have port a_count  output  CNT_W  words accepted for A since reset or clear.
REQ-016 SHALL have port b_count  output  CNT_W  words accepted for B since reset or clear.

Function
REQ-017 SHALL implement two independent DEPTH-entry FIFO buffers, A and B, each with its own read pointer, write pointer and occupancy.
REQ-018 SHALL drive in_ready = (in_sel ? A occupancy < DEPTH : B occupancy < DEPTH), derived from registered occupancy only; no combinational path from a_ready or b_ready to in_ready.
REQ-019 SHALL treat a push as occurring when in_valid && in_ready: in_data is written into the buffer selected by in_sel, and that buffer's write pointer advances.
REQ-020 SHALL treat a pop as occurring when X_valid && X_ready (X = a or b): the buffer's read pointer advances.
REQ-021 SHALL make a pushed word visible on X_valid/X_data on the cycle after the push (latency 1); no combinational bypass from input to output.
REQ-022 SHALL preserve word order within each port; no ordering relation between ports.
REQ-023 SHALL allow a simultaneous push and pop on the same buffer when it is not full: occupancy stays unchanged and both pointers advance.
REQ-024 SHALL refuse a push to a full buffer (in_ready=0) even if a pop on that buffer occurs in the same cycle; the push is accepted on the following cycle.
REQ-025 SHALL leave a full buffer's contents untouched while its in_ready is deasserted.
REQ-026 SHALL keep in_ready high for port B while A is full, and vice versa; a stall on one port does not block the other.
REQ-027 SHALL wrap both pointers modulo DEPTH.
REQ-028 SHALL hold X_data stable while X_valid=1 and X_ready=0.
REQ-029 SHALL ignore X_ready while X_valid=0; no pop, and occupancy never goes negative.
REQ-030 SHALL increment the counter of the destination port on every push.
REQ-031 SHALL make each counter saturate at 2^CNT_W-1 rather than wrap.
REQ-032 SHALL have cnt_clr take priority over a same-cycle increment: the counter becomes 0, and that push is not counted.
REQ-033 SHALL leave X_data undefined-but-stable (last value) when X_valid=0; the bench does not check it.

Reset
REQ-034 SHALL, when rst=1 at a rising edge, clear both occupancies, all pointers, a_count and b_count to 0.
REQ-035 SHALL hold a_valid=0, b_valid=0 and in_ready=0 during reset; in_ready rises on the first cycle after rst is released.
REQ-036 SHALL have reset mid-operation discard all buffered words; no pops or pushes occur in the reset cycle.
REQ-037 SHALL have rst take priority over cnt_clr, pushes and pops.

Verification
REQ-038 SHALL verify steering: push 0x0000_0001 with sel=1, then 0x0000_0002 with sel=0, both readies high -> a_data=0x1 valid one cycle after its push, b_data=0x2 likewise; a_count=1, b_count=1.
REQ-039 SHALL verify backpressure: a_ready=0, push 3 words with sel=1 -> first 2 accepted, in_ready=0 on the third; with sel=0 in_ready=1 meanwhile; raise a_ready -> words drain in order 1,2, and the third is accepted one cycle after the first pop.
REQ-040 SHALL verify full-plus-pop: A full, a_ready=1 and in_valid=1 with sel=1 in the same cycle -> no push that cycle, occupancy 1 next cycle, push accepted the following cycle.
REQ-041 SHALL verify streaming: both readies high, alternating sel for 100 words -> zero stall cycles, each port receives 50 words in order, counts=50/50.
REQ-042 SHALL verify reset mid-operation: both buffers holding 2 words, rst pulsed 1 cycle -> next cycle a_valid=b_valid=0, counts=0, in_ready=1.
REQ-043 SHALL verify counters: with CNT_W=4, 20 pushes to B -> b_count=15 (saturated); cnt_clr with a concurrent push -> b_count=0.
